// File: rtl/scarv_cop_pkg.sv
// Shared types and constants for the SCARV coprocessor register file.
// Holds the clear-sequencer state encoding and the write byte-lane width.
package scarv_cop_pkg;

    localparam int SCARV_COP_LANE_W = 8;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/scarv_cop_regfile_clr.sv
// Clear sequencer for xc.init: walks every register once, writing zeros,
// then holds a done indication until the request is dropped.
module scarv_cop_regfile_clr
    import scarv_cop_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          cprs_init,
    output logic          clr_wen,
    output logic [AW-1:0] clr_addr,
    output logic          done,
    output logic          busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] cnt_nxt;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state   <= CLR_IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= cnt_nxt;
        end
    end

    // IDLE and CLEAR share the write step; IDLE always starts from entry 0.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = clr_cnt;
        clr_wen   = 1'b0;
        done      = 1'b0;
        case (state)
            CLR_IDLE, CLR_CLEAR: begin
                if (cprs_init) begin
                    clr_wen = 1'b1;
                    if (clr_cnt == LAST) begin
                        state_nxt = CLR_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = CLR_CLEAR;
                        cnt_nxt   = clr_cnt + AW'(1);
                    end
                end else begin
                    state_nxt = CLR_IDLE;
                    cnt_nxt   = '0;
                end
            end
            CLR_DONE: begin
                done = cprs_init;
                if (!cprs_init) begin
                    state_nxt = CLR_IDLE;
                end
            end
            default: begin
                state_nxt = CLR_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign clr_addr = clr_cnt;
    assign busy     = (state != CLR_IDLE);

endmodule

// File: rtl/scarv_cop_regfile.sv
// Parametrised COP general-purpose register file: NREAD combinational read
// ports, one byte-lane-masked write port, sequenced clear and optional bypass.
module scarv_cop_regfile
    import scarv_cop_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int DEPTH  = 16,
    parameter  int NREAD  = 3,
    parameter  int BYPASS = 0,
    localparam int NLANE  = XLEN / SCARV_COP_LANE_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    output logic                  g_clk_req,
    input  logic                  cprs_init,
    output logic                  cprs_init_done,
    input  logic [NREAD-1:0]      crs_ren,
    input  logic [NREAD*AW-1:0]   crs_addr,
    output logic [NREAD*XLEN-1:0] crs_rdata,
    input  logic [NLANE-1:0]      crd_wen,
    input  logic [AW-1:0]         crd_addr,
    input  logic [XLEN-1:0]       crd_wdata
);

    logic [NLANE-1:0][SCARV_COP_LANE_W-1:0] mem [DEPTH];

    logic             clr_wen;
    logic [AW-1:0]    clr_addr;
    logic             clr_done;
    logic             clr_busy;
    logic [NLANE-1:0] ew_wen;
    logic [AW-1:0]    ew_addr;
    logic [XLEN-1:0]  ew_wdata;

    scarv_cop_regfile_clr #(
        .DEPTH (DEPTH)
    ) u_clr (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .cprs_init (cprs_init),
        .clr_wen   (clr_wen),
        .clr_addr  (clr_addr),
        .done      (clr_done),
        .busy      (clr_busy)
    );

    // The writeback port is locked out for the whole of xc.init, even in DONE.
    assign ew_wen   = cprs_init ? {NLANE{clr_wen}} : crd_wen;
    assign ew_addr  = cprs_init ? clr_addr : crd_addr;
    assign ew_wdata = cprs_init ? '0 : crd_wdata;

    always_ff @(posedge g_clk) begin
        for (int l = 0; l < NLANE; l++) begin
            if (ew_wen[l]) begin
                mem[ew_addr][l] <= ew_wdata[l*SCARV_COP_LANE_W +: SCARV_COP_LANE_W];
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] raddr;
        assign raddr = crs_addr[p*AW +: AW];

        for (genvar l = 0; l < NLANE; l++) begin : g_lane
            logic hit;
            assign hit = (BYPASS != 0) && ew_wen[l] && (ew_addr == raddr);
            assign crs_rdata[p*XLEN + l*SCARV_COP_LANE_W +: SCARV_COP_LANE_W] =
                !crs_ren[p] ? '0 :
                hit         ? ew_wdata[l*SCARV_COP_LANE_W +: SCARV_COP_LANE_W] :
                              mem[raddr][l];
        end
    end

    assign cprs_init_done = clr_done;
    assign g_clk_req      = (|crd_wen) | cprs_init | clr_busy;

endmodule

// File: tb/tb_scarv_cop_regfile.sv
// Directed self-checking bench for scarv_cop_regfile: default build, a
// bypass build sharing its inputs, and a 64x32x4 build.
module tb_scarv_cop_regfile;

    logic        g_clk = 1'b0;
    logic        g_reset = 1'b0;
    logic        cprs_init = 1'b0;
    logic [2:0]  crs_ren = '0;
    logic [11:0] crs_addr = '0;
    logic [3:0]  crd_wen = '0;
    logic [3:0]  crd_addr = '0;
    logic [31:0] crd_wdata = '0;
    logic [95:0] rdata0, rdata1;
    logic        done0, done1, req0, req1;

    logic        p_init = 1'b0;
    logic [3:0]  p_ren = '0;
    logic [19:0] p_addr = '0;
    logic [255:0] p_rdata;
    logic [7:0]  p_wen = '0;
    logic [4:0]  p_waddr = '0;
    logic [63:0] p_wdata = '0;
    logic        p_done, p_req;

    int testsRun = 0;
    int testsFailed = 0;
    int edges;

    always #5 g_clk = ~g_clk;

    scarv_cop_regfile #(.XLEN(32), .DEPTH(16), .NREAD(3), .BYPASS(0)) dut0 (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(req0),
        .cprs_init(cprs_init), .cprs_init_done(done0),
        .crs_ren(crs_ren), .crs_addr(crs_addr), .crs_rdata(rdata0),
        .crd_wen(crd_wen), .crd_addr(crd_addr), .crd_wdata(crd_wdata));

    scarv_cop_regfile #(.XLEN(32), .DEPTH(16), .NREAD(3), .BYPASS(1)) dut1 (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(req1),
        .cprs_init(cprs_init), .cprs_init_done(done1),
        .crs_ren(crs_ren), .crs_addr(crs_addr), .crs_rdata(rdata1),
        .crd_wen(crd_wen), .crd_addr(crd_addr), .crd_wdata(crd_wdata));

    scarv_cop_regfile #(.XLEN(64), .DEPTH(32), .NREAD(4), .BYPASS(0)) dut2 (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(p_req),
        .cprs_init(p_init), .cprs_init_done(p_done),
        .crs_ren(p_ren), .crs_addr(p_addr), .crs_rdata(p_rdata),
        .crd_wen(p_wen), .crd_addr(p_waddr), .crd_wdata(p_wdata));

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [3:0] wen, input logic [31:0] data);
        crd_addr  = addr;
        crd_wen   = wen;
        crd_wdata = data;
        tick();
        crd_wen   = '0;
    endtask

    task automatic readCheck(input string tag, input int p, input logic [3:0] addr,
                             input logic [31:0] exp, input bit chkByp);
        crs_ren[p] = 1'b1;
        crs_addr[p*4 +: 4] = addr;
        #1;
        checkOutput(tag, {32'h0, rdata0[p*32 +: 32]}, {32'h0, exp});
        if (chkByp) checkOutput({tag, "_byp"}, {32'h0, rdata1[p*32 +: 32]}, {32'h0, exp});
        crs_ren[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // reset asserted and released between edges
        #3 g_reset = 1'b1;
        #19 g_reset = 1'b0;
        #1;
        checkOutput("rst_rdata0", {32'h0, rdata0[63:0] | {32'h0, rdata0[95:64]}}, 64'h0);
        checkOutput("rst_rdata1", {32'h0, rdata1[63:0] | {32'h0, rdata1[95:64]}}, 64'h0);
        checkOutput("rst_done", {63'h0, done0}, 64'h0);
        checkOutput("rst_req0", {63'h0, req0}, 64'h0);
        checkOutput("rst_req1", {63'h0, req1}, 64'h0);

        // byte-lane masked write
        tick();
        crd_wen = 4'hF;
        #1;
        checkOutput("req_on_wen", {63'h0, req0}, 64'h1);
        applyStimulus(4'd5, 4'hF, 32'hAABBCCDD);
        applyStimulus(4'd5, 4'b0101, 32'h11223344);
        readCheck("lane_r5", 2, 4'd5, 32'hAA22CC44, 1'b1);

        // full clear with an ignored writeback attempt to r3
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), 4'hF, 32'hFFFFFFFF);
        cprs_init = 1'b1;
        crd_wen   = 4'hF;
        crd_addr  = 4'd3;
        crd_wdata = 32'h12345678;
        edges = 0;
        while (done0 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput("clr_edges", 64'(edges), 64'd16);
        checkOutput("clr_done_byp", {63'h0, done1}, 64'h1);
        crd_wen = '0;
        for (int i = 0; i < 16; i++) readCheck($sformatf("clr_r%0d", i), 0, 4'(i), 32'h0, 1'b1);
        cprs_init = 1'b0;
        #1;
        checkOutput("done_drops", {63'h0, done0}, 64'h0);
        checkOutput("req_in_done", {63'h0, req0}, 64'h1);
        tick();
        checkOutput("req_idle", {63'h0, req0}, 64'h0);

        // aborted clear after five edges, then restart
        for (int i = 0; i < 16; i++) applyStimulus(4'(i), 4'hF, 32'hFFFFFFFF);
        cprs_init = 1'b1;
        repeat (5) tick();
        cprs_init = 1'b0;
        tick();
        for (int i = 0; i < 16; i++)
            readCheck($sformatf("abort_r%0d", i), 1, 4'(i), (i < 5) ? 32'h0 : 32'hFFFFFFFF, 1'b1);
        applyStimulus(4'd0, 4'hF, 32'hFFFFFFFF);
        applyStimulus(4'd1, 4'hF, 32'hFFFFFFFF);
        cprs_init = 1'b1;
        tick();
        readCheck("restart_r0", 0, 4'd0, 32'h0, 1'b1);
        readCheck("restart_r1", 0, 4'd1, 32'hFFFFFFFF, 1'b0);
        edges = 1;
        while (done0 !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checkOutput("restart_edges", 64'(edges), 64'd16);
        cprs_init = 1'b0;
        tick();

        // same-cycle write and read of r9
        applyStimulus(4'd9, 4'hF, 32'h01010101);
        crd_addr  = 4'd9;
        crd_wen   = 4'hF;
        crd_wdata = 32'hDEADBEEF;
        crs_ren   = 3'b101;
        crs_addr  = {4'd9, 4'd9, 4'd9};
        #1;
        checkOutput("byp_p0", {32'h0, rdata1[31:0]}, {32'h0, 32'hDEADBEEF});
        checkOutput("byp_p2", {32'h0, rdata1[95:64]}, {32'h0, 32'hDEADBEEF});
        checkOutput("nobyp_p0", {32'h0, rdata0[31:0]}, {32'h0, 32'h01010101});
        checkOutput("nobyp_p2", {32'h0, rdata0[95:64]}, {32'h0, 32'h01010101});
        checkOutput("ren_low_p1", {32'h0, rdata1[63:32]}, 64'h0);
        tick();
        crd_wen = '0;
        crs_ren = '0;
        readCheck("after_wr_r9", 0, 4'd9, 32'hDEADBEEF, 1'b1);

        // wide build: partial-lane write to r31
        p_waddr = 5'd31;
        p_wen   = 8'hFF;
        p_wdata = 64'hFFEEDDCC_BBAA9988;
        tick();
        p_wen   = 8'h0F;
        p_wdata = 64'h01234567_89ABCDEF;
        tick();
        p_wen   = '0;
        p_ren   = 4'b1000;
        p_addr  = {5'd31, 15'h0};
        #1;
        checkOutput("wide_r31", p_rdata[255:192], 64'hFFEEDDCC_89ABCDEF);
        checkOutput("wide_ren_low", p_rdata[63:0], 64'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
